ni_calc_pack: RTL and testbench

- Parametrised successor to the single-channel noise-impulse threshold comparator.
- Per sample it scales S by a runtime gain, drops FRAC fractional bits, saturates to WIDTH bits, and compares the result against the neighbourhood sum using a selectable mode.
- It packs the per-sample decision bits LSB-first into PACK_BITS words and counts ones per frame.
- It sits between the window-sum stage and the NIRD mask writer.

---
 rtl/ni_calc_pack.sv | 171 +++++++++++++++++
 tb/tb_ni_calc_pack.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ni_calc_pack.sv
// Scales S by a per-frame gain, compares against the neighbourhood sum, then packs the
// decision bits LSB-first into words and counts ones per frame.
//   state  | meaning
//   IDLE   | between frames; the next done_i latches gain/mode
//   ACTIVE | inside a frame; gain/mode frozen until done_i&last_i
module ni_calc_pack #(
    parameter int WIDTH      = 10,
    parameter int S_WIDTH    = 24,
    parameter int GAIN_WIDTH = 8,
    parameter int FRAC       = 16,
    parameter int HYST       = 4,
    parameter int PACK_BITS  = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int LEN_W      = $clog2(PACK_BITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GAIN_WIDTH-1:0] gain_i,
    input  logic [1:0]            mode_i,
    input  logic [S_WIDTH-1:0]    S,
    input  logic [WIDTH-1:0]      sum_i,
    input  logic                  done_i,
    input  logic                  last_i,
    output logic                  bit_o,
    output logic                  bit_valid_o,
    output logic [PACK_BITS-1:0]  word_o,
    output logic [LEN_W-1:0]      word_len_o,
    output logic                  word_valid_o,
    output logic [CNT_WIDTH-1:0]  ones_cnt_o,
    output logic                  frame_done_o
);
    localparam int PW = S_WIDTH + GAIN_WIDTH;

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;

    logic                  latch_en;
    logic [GAIN_WIDTH-1:0] gain_q, gain_eff;
    logic [1:0]            mode_q, mode_eff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (done_i && !last_i) state_nx = ACTIVE;
            ACTIVE:  if (done_i && last_i)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        latch_en = (state == IDLE) && done_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gain_q <= '0;
            mode_q <= '0;
        end else if (latch_en) begin
            gain_q <= gain_i;
            mode_q <= mode_i;
        end
    end

    // The first sample of a frame uses the values being latched on that same edge.
    assign gain_eff = latch_en ? gain_i : gain_q;
    assign mode_eff = latch_en ? mode_i : mode_q;

    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] thr_c;
    assign prod  = PW'(S) * PW'(gain_eff);
    assign thr_c = (|prod[PW-1:FRAC+WIDTH]) ? '1 : prod[FRAC+WIDTH-1:FRAC];

    logic             v1, last1, last2;
    logic [WIDTH-1:0] thr1, sum1;
    logic [1:0]       mode1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            thr1  <= '0;
            sum1  <= '0;
            last1 <= 1'b0;
            mode1 <= '0;
        end else begin
            v1 <= done_i;
            if (done_i) begin
                thr1  <= thr_c;
                sum1  <= sum_i;
                last1 <= last_i;
                mode1 <= mode_eff;
            end
        end
    end

    logic [WIDTH:0] diff;
    logic           cmp_bit;

    always_comb begin
        diff = (thr1 >= sum1) ? ({1'b0, thr1} - {1'b0, sum1}) : ({1'b0, sum1} - {1'b0, thr1});
        cmp_bit = 1'b0;
        case (mode1)
            2'd0:    cmp_bit = thr1 >= sum1;
            2'd1:    cmp_bit = thr1 > sum1;
            2'd2:    cmp_bit = thr1 < sum1;
            default: cmp_bit = diff <= (WIDTH+1)'(HYST);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_o       <= 1'b0;
            bit_valid_o <= 1'b0;
            last2       <= 1'b0;
        end else begin
            bit_valid_o <= v1;
            if (v1) begin
                bit_o <= cmp_bit;
                last2 <= last1;
            end
        end
    end

    logic [PACK_BITS-1:0] pbuf, word_nx;
    logic [LEN_W-1:0]     pcnt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx;
    logic                 word_end;

    always_comb begin
        word_nx  = pbuf | (bit_o ? (PACK_BITS'(1) << pcnt) : '0);
        cnt_nx   = (bit_o && (cnt != '1)) ? cnt + CNT_WIDTH'(1) : cnt;
        word_end = bit_valid_o && ((pcnt == LEN_W'(PACK_BITS - 1)) || last2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pbuf         <= '0;
            pcnt         <= '0;
            cnt          <= '0;
            word_o       <= '0;
            word_len_o   <= '0;
            word_valid_o <= 1'b0;
            ones_cnt_o   <= '0;
            frame_done_o <= 1'b0;
        end else begin
            word_valid_o <= word_end;
            frame_done_o <= bit_valid_o && last2;
            if (bit_valid_o) begin
                if (word_end) begin
                    word_o     <= word_nx;
                    word_len_o <= pcnt + LEN_W'(1);
                    pbuf       <= '0;
                    pcnt       <= '0;
                end else begin
                    pbuf <= word_nx;
                    pcnt <= pcnt + LEN_W'(1);
                end
                if (last2) begin
                    ones_cnt_o <= cnt_nx;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_ni_calc_pack.sv
// Directed bench for ni_calc_pack: compare modes, saturation, packing, frame control, reset.
module tb_ni_calc_pack;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  gain_i = '0;
    logic [1:0]  mode_i = '0;
    logic [23:0] S = '0;
    logic [9:0]  sum_i = '0;
    logic        done_i = 1'b0;
    logic        last_i = 1'b0;
    logic        bit_o, bit_valid_o, word_valid_o, frame_done_o;
    logic [15:0] word_o, ones_cnt_o;
    logic [4:0]  word_len_o;

    localparam logic [23:0] S100 = 24'h640000;  // thr = 100 at gain 1

    ni_calc_pack dut (
        .clk(clk), .rst(rst), .gain_i(gain_i), .mode_i(mode_i), .S(S), .sum_i(sum_i),
        .done_i(done_i), .last_i(last_i), .bit_o(bit_o), .bit_valid_o(bit_valid_o),
        .word_o(word_o), .word_len_o(word_len_o), .word_valid_o(word_valid_o),
        .ones_cnt_o(ones_cnt_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] bits_q[$], words_q[$], lens_q[$], fdw_q[$], ones_q[$];

    always @(negedge clk) begin
        if (bit_valid_o) bits_q.push_back(32'(bit_o));
        if (word_valid_o) begin
            words_q.push_back(32'(word_o));
            lens_q.push_back(32'(word_len_o));
            fdw_q.push_back(32'(frame_done_o));
        end
        if (frame_done_o) ones_q.push_back(32'(ones_cnt_o));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic clr_q();
        bits_q.delete(); words_q.delete(); lens_q.delete(); fdw_q.delete(); ones_q.delete();
    endtask

    task automatic drive(input logic [23:0] s, input logic [9:0] sm, input logic [7:0] g,
                         input logic [1:0] m, input logic l);
        S = s; sum_i = sm; gain_i = g; mode_i = m; last_i = l; done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0; last_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bit_valid", 32'(bit_valid_o), 0);
        chk("rst_word_valid", 32'(word_valid_o), 0);
        chk("rst_frame_done", 32'(frame_done_o), 0);
        chk("rst_ones", 32'(ones_cnt_o), 0);
        chk("rst_word", 32'(word_o), 0);
        rst = 1'b1;
        idle(2);

        // Latency and mode 0 edge: thr = 0x3F
        clr_q();
        drive(24'h028F5C, 10'h03F, 8'd25, 2'd0, 1'b0);
        chk("t1_bv_early", 32'(bit_valid_o), 0);
        drive(24'h028F5C, 10'h040, 8'd25, 2'd0, 1'b1);
        chk("t1_bv_a", 32'(bit_valid_o), 1);
        chk("t1_bit_a", 32'(bit_o), 1);
        idle(1);
        chk("t1_bv_b", 32'(bit_valid_o), 1);
        chk("t1_bit_b", 32'(bit_o), 0);
        chk("t1_wv_early", 32'(word_valid_o), 0);
        idle(1);
        chk("t1_wv", 32'(word_valid_o), 1);
        chk("t1_word", 32'(word_o), 32'h1);
        chk("t1_len", 32'(word_len_o), 2);
        chk("t1_fd", 32'(frame_done_o), 1);
        chk("t1_ones", 32'(ones_cnt_o), 1);
        idle(1);
        chk("t1_wv_off", 32'(word_valid_o), 0);
        chk("t1_bit_hold", 32'(bit_o), 0);
        chk("t1_ones_hold", 32'(ones_cnt_o), 1);

        // Saturation: thr = 0x3FF
        clr_q();
        drive(24'hFFFFFF, 10'h3FF, 8'hFF, 2'd1, 1'b1);
        drive(24'hFFFFFF, 10'h3FF, 8'hFF, 2'd0, 1'b1);
        idle(5);
        chk("t2_nbits", bits_q.size(), 2);
        chk("t2_bit_m1", qget(bits_q, 0), 0);
        chk("t2_bit_m0", qget(bits_q, 1), 1);
        chk("t2_nwords", words_q.size(), 2);
        chk("t2_len0", qget(lens_q, 0), 1);
        chk("t2_word1", qget(words_q, 1), 1);
        chk("t2_ones0", qget(ones_q, 0), 0);
        chk("t2_ones1", qget(ones_q, 1), 1);

        // Mode 3 window then mode 2
        clr_q();
        drive(S100, 10'd96,  8'd1, 2'd3, 1'b0);
        drive(S100, 10'd104, 8'd1, 2'd3, 1'b0);
        drive(S100, 10'd95,  8'd1, 2'd3, 1'b0);
        drive(S100, 10'd105, 8'd1, 2'd3, 1'b1);
        drive(S100, 10'd101, 8'd1, 2'd2, 1'b1);
        idle(5);
        chk("t3_nbits", bits_q.size(), 5);
        chk("t3_b96", qget(bits_q, 0), 1);
        chk("t3_b104", qget(bits_q, 1), 1);
        chk("t3_b95", qget(bits_q, 2), 0);
        chk("t3_b105", qget(bits_q, 3), 0);
        chk("t3_m2", qget(bits_q, 4), 1);
        chk("t3_word0", qget(words_q, 0), 32'h3);
        chk("t3_len0", qget(lens_q, 0), 4);
        chk("t3_ones0", qget(ones_q, 0), 2);

        // 20-sample alternating frame: full word then remainder
        clr_q();
        for (int i = 0; i < 20; i++)
            drive(S100, (i % 2 == 1) ? 10'd101 : 10'd100, 8'd1, 2'd0, i == 19);
        idle(5);
        chk("t4_nwords", words_q.size(), 2);
        chk("t4_word0", qget(words_q, 0), 32'h5555);
        chk("t4_len0", qget(lens_q, 0), 16);
        chk("t4_fd0", qget(fdw_q, 0), 0);
        chk("t4_word1", qget(words_q, 1), 32'h5);
        chk("t4_len1", qget(lens_q, 1), 4);
        chk("t4_fd1", qget(fdw_q, 1), 1);
        chk("t4_nfd", ones_q.size(), 1);
        chk("t4_ones", qget(ones_q, 0), 10);

        // Mid-frame gain/mode changes ignored; next frame picks them up
        clr_q();
        drive(S100, 10'd100, 8'd1, 2'd0, 1'b0);
        drive(S100, 10'd50,  8'd0, 2'd1, 1'b0);
        drive(S100, 10'd100, 8'd0, 2'd1, 1'b1);
        drive(S100, 10'd0,   8'd0, 2'd1, 1'b1);
        idle(5);
        chk("t5_b1", qget(bits_q, 1), 1);
        chk("t5_b2", qget(bits_q, 2), 1);
        chk("t5_newframe", qget(bits_q, 3), 0);
        chk("t5_word0", qget(words_q, 0), 32'h7);
        chk("t5_len1", qget(lens_q, 1), 1);
        chk("t5_ones0", qget(ones_q, 0), 3);

        // Reset mid-frame, then a clean 3-sample frame
        for (int i = 0; i < 5; i++) drive(S100, 10'd100, 8'd1, 2'd0, 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_rst_bv", 32'(bit_valid_o), 0);
        chk("t6_rst_ones", 32'(ones_cnt_o), 0);
        idle(2);
        rst = 1'b1;
        clr_q();
        idle(1);
        drive(S100, 10'd100, 8'd1, 2'd0, 1'b0);
        drive(S100, 10'd101, 8'd1, 2'd0, 1'b0);
        drive(S100, 10'd100, 8'd1, 2'd0, 1'b1);
        idle(6);
        chk("t6_nwords", words_q.size(), 1);
        chk("t6_word", qget(words_q, 0), 32'h5);
        chk("t6_len", qget(lens_q, 0), 3);
        chk("t6_fd", qget(fdw_q, 0), 1);
        chk("t6_nfd", ones_q.size(), 1);
        chk("t6_ones", qget(ones_q, 0), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
